// File: rtl/seq_bcd_converter_if.sv
// seq_bcd_converter_if: handshake and result bundle for seq_bcd_converter.
//   in_valid  upstream word valid        in_ready  converter idle, can accept
//   bin       signed word to convert     busy      conversion in progress
//   out_valid one-cycle new-result pulse sign      result negative
//   bcd       packed BCD digits, digit 0 = ones
//   blank     leading-zero flags per digit (only with BCD_LZ_BLANK_EN)
// master: upstream / consumer side. slave: the converter.
interface seq_bcd_converter_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  out_valid;
   logic                  sign;
   logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0]     blank;
`endif

   modport master (
      output in_valid,
      output bin,
      input  in_ready,
      input  busy,
      input  out_valid,
      input  sign,
`ifdef BCD_LZ_BLANK_EN
      input  blank,
`endif
      input  bcd
   );

   modport slave (
      input  in_valid,
      input  bin,
      output in_ready,
      output busy,
      output out_valid,
      output sign,
`ifdef BCD_LZ_BLANK_EN
      output blank,
`endif
      output bcd
   );
endinterface

// File: rtl/seq_bcd_converter.sv
// seq_bcd_converter: multi-cycle signed binary to sign + BCD converter using
// shift-add-3 (double dabble), one input bit per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    seq_bcd_converter_if.slave (in_valid/in_ready/bin in,
//          busy/out_valid/sign/bcd[/blank] out)
// Optional macro BCD_LZ_BLANK_EN adds the registered leading-zero blank flags.
// Results (sign, bcd, blank) are only updated on the DONE edge, so the
// display never sees intermediate shift values.
module seq_bcd_converter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input logic                  clk,
   input logic                  reset,
   seq_bcd_converter_if.slave   bus
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned BcdW = 4 * DIGITS;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic            in_ready;
   logic            busy;
   logic            accept;
   logic [WIDTH-1:0] mag_in;
   logic [BcdW-1:0] bcd_adj;

   logic            neg_q;
   logic [WIDTH-1:0] mag_q;
   logic [BcdW-1:0] work_q;
   logic [CntW-1:0] cnt_q;
   logic            sign_q;
   logic [BcdW-1:0] bcd_q;
   logic            out_valid_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid) state_d = StShift;
         StShift: if (cnt_q == CntW'(1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == StIdle);
      busy     = (state_q == StShift) || (state_q == StDone);
   end

   assign accept = in_ready && bus.in_valid;

   // Two's-complement negate in WIDTH bits; the most-negative input maps to
   // 2^(WIDTH-1), which still fits as an unsigned magnitude.
   assign mag_in = bus.bin[WIDTH-1] ? (~bus.bin + WIDTH'(1)) : bus.bin;

   // Add-3 correction applied to every digit before the shift
   always_comb begin
      bcd_adj = work_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (work_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0] blank_d;
   logic [DIGITS-1:0] blank_q;
   logic              zero_above;

   // Digit i is blanked when it and every higher digit are zero; ones never.
   always_comb begin
      blank_d    = '0;
      zero_above = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_above = zero_above && (work_q[4*i +: 4] == 4'd0);
         blank_d[i] = zero_above;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  blank_q <= '0;
      else if (state_q == StDone) blank_q <= blank_d;
   end

   assign bus.blank = blank_q;
`endif

   // Conversion datapath and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q       <= 1'b0;
         mag_q       <= '0;
         work_q      <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         bcd_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  neg_q  <= bus.bin[WIDTH-1];
                  mag_q  <= mag_in;
                  work_q <= '0;
                  cnt_q  <= CntW'(WIDTH);
               end
            end
            StShift: begin
               {work_q, mag_q} <= {bcd_adj[BcdW-2:0], mag_q, 1'b0};
               cnt_q           <= cnt_q - CntW'(1);
            end
            StDone: begin
               sign_q      <= neg_q;
               bcd_q       <= work_q;
               out_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.out_valid = out_valid_q;
   assign bus.sign      = sign_q;
   assign bus.bcd       = bcd_q;
endmodule

// File: tb/tb_seq_bcd_converter.sv
// tb_seq_bcd_converter: randomized and directed checks of seq_bcd_converter
// against an arithmetic reference model (abs value, repeated divide by ten).
module tb_seq_bcd_converter;
   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DIGITS = 5;
   localparam int          LAT    = WIDTH + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   asserts  = 0;
   int   failures = 0;

   logic        prev_sign = 1'b0;
   logic [19:0] prev_bcd  = '0;

   seq_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   seq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int ref_mag(input logic [15:0] v);
      int m;
      m = int'($signed(v));
      if (m < 0) m = -m;
      return m;
   endfunction

   function automatic logic ref_sign(input logic [15:0] v);
      return int'($signed(v)) < 0;
   endfunction

   function automatic logic [19:0] ref_bcd(input logic [15:0] v);
      int m;
      logic [19:0] r;
      m = ref_mag(v);
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] ref_blank(input logic [15:0] v);
      logic [4:0] b;
      int p;
      b = '0;
      p = 1;
      for (int i = 1; i < 5; i++) begin
         p = p * 10;
         b[i] = ref_mag(v) < p;
      end
      return b;
   endfunction

   // Accept v, then count edges until out_valid. Also counts in_ready-low
   // cycles and cycles where sign/bcd differ from the held previous result.
   task automatic do_convert(input logic [15:0] v, input logic hold_sign,
                             input logic [19:0] hold_bcd, output int lat,
                             output int ready_low, output int changes);
      lat = -1;
      ready_low = 0;
      changes = 0;
      for (int i = 0; i < 50 && !bus.in_ready; i++) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.bin      = v;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.bin      = 16'($urandom);
      for (int n = 1; n <= 40; n++) begin
         if (!bus.in_ready) ready_low++;
         if (bus.sign !== hold_sign || bus.bcd !== hold_bcd) changes++;
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      asserts++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      asserts++;
      if (bus.sign !== 1'b0) begin
         failures++; $display("FAIL reset_sign: got %b want 0", bus.sign);
      end
      asserts++;
      if (bus.bcd !== 20'h0) begin
         failures++; $display("FAIL reset_bcd: got %h want 00000", bus.bcd);
      end
      asserts++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      asserts++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      prev_sign = 1'b0;
      prev_bcd  = '0;
   endtask

   task automatic test_zero_latency();
      int lat, rl, ch;
      do_convert(16'h0000, prev_sign, prev_bcd, lat, rl, ch);
      asserts++;
      if (lat !== LAT) begin
         failures++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
      end
      asserts++;
      if (rl !== LAT) begin
         failures++; $display("FAIL zero_ready_low: got %0d want %0d", rl, LAT);
      end
      asserts++;
      if (bus.sign !== 1'b0 || bus.bcd !== 20'h0) begin
         failures++; $display("FAIL zero_result: got %b/%h want 0/00000", bus.sign, bus.bcd);
      end
      @(posedge clk); #1;
      asserts++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL zero_pulse_width: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_values();
      logic [15:0] vals [4];
      int lat, rl, ch;
      vals = '{16'd12345, 16'hFFFF, 16'h8000, 16'h7FFF};
      foreach (vals[k]) begin
         do_convert(vals[k], prev_sign, prev_bcd, lat, rl, ch);
         asserts++;
         if (bus.sign !== ref_sign(vals[k]) || bus.bcd !== ref_bcd(vals[k])) begin
            failures++;
            $display("FAIL value_%h: got %b/%h want %b/%h", vals[k], bus.sign, bus.bcd,
                     ref_sign(vals[k]), ref_bcd(vals[k]));
         end
         asserts++;
         if (ch !== 0) begin
            failures++; $display("FAIL value_hold_%h: got %0d changes want 0", vals[k], ch);
         end
         prev_sign = ref_sign(vals[k]);
         prev_bcd  = ref_bcd(vals[k]);
      end
   endtask

   task automatic test_busy_ignore();
      int first_n, second_n, pulses;
      logic [19:0] first_bcd, second_bcd;
      first_n = 0; second_n = -1; pulses = 0;
      first_bcd = '0; second_bcd = '0;
      for (int i = 0; i < 50 && !bus.in_ready; i++) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.bin      = 16'd100;
      @(posedge clk); #1;
      bus.bin = 16'd99;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (first_n > 0 && n == first_n + 1) bus.in_valid = 1'b0;
         if (bus.out_valid) begin
            pulses++;
            if (pulses == 1) begin
               first_n = n; first_bcd = bus.bcd;
            end else begin
               second_n = n; second_bcd = bus.bcd;
               break;
            end
         end
      end
      bus.in_valid = 1'b0;
      asserts++;
      if (first_n !== LAT || first_bcd !== 20'h00100) begin
         failures++;
         $display("FAIL busy_first: got n=%0d bcd=%h want n=%0d bcd=00100", first_n, first_bcd, LAT);
      end
      asserts++;
      if (second_n !== 2 * LAT + 1 || second_bcd !== 20'h00099) begin
         failures++;
         $display("FAIL busy_second: got n=%0d bcd=%h want n=%0d bcd=00099", second_n, second_bcd,
                  2 * LAT + 1);
      end
      prev_sign = 1'b0;
      prev_bcd  = 20'h00099;
   endtask

   task automatic test_reset_abort();
      int lat, rl, ch, spurious;
      logic [15:0] v;
      v = 16'(-250);
      do_convert(v, prev_sign, prev_bcd, lat, rl, ch);
      asserts++;
      if (bus.sign !== 1'b1 || bus.bcd !== 20'h00250) begin
         failures++; $display("FAIL abort_pre: got %b/%h want 1/00250", bus.sign, bus.bcd);
      end
      bus.in_valid = 1'b1;
      bus.bin      = 16'd9999;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      asserts++;
      if (bus.out_valid !== 1'b0 || bus.sign !== 1'b0 || bus.bcd !== 20'h0 || bus.busy !== 1'b0)
      begin
         failures++;
         $display("FAIL abort_clear: got ov=%b sign=%b bcd=%h busy=%b want 0/0/00000/0",
                  bus.out_valid, bus.sign, bus.bcd, bus.busy);
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      asserts++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready);
      end
      spurious = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.out_valid) spurious++;
      end
      asserts++;
      if (spurious !== 0) begin
         failures++; $display("FAIL abort_discard: got %0d pulses want 0", spurious);
      end
      do_convert(16'd7, 1'b0, 20'h0, lat, rl, ch);
      asserts++;
      if (lat !== LAT || bus.sign !== 1'b0 || bus.bcd !== 20'h00007 || ch !== 0) begin
         failures++;
         $display("FAIL abort_after: got lat=%0d %b/%h ch=%0d want %0d 0/00007 0", lat,
                  bus.sign, bus.bcd, ch, LAT);
      end
      prev_sign = 1'b0;
      prev_bcd  = 20'h00007;
   endtask

   // Each conversion is accepted in the cycle the previous out_valid is high.
   task automatic test_back_to_back();
      int lat, rl, ch;
      logic [15:0] v;
      for (int k = 0; k < 25; k++) begin
         v = 16'($urandom);
         do_convert(v, prev_sign, prev_bcd, lat, rl, ch);
         asserts++;
         if (lat !== LAT || ch !== 0 || bus.sign !== ref_sign(v) || bus.bcd !== ref_bcd(v))
         begin
            failures++;
            $display("FAIL b2b_%h: got lat=%0d ch=%0d %b/%h want %0d 0 %b/%h", v, lat, ch,
                     bus.sign, bus.bcd, LAT, ref_sign(v), ref_bcd(v));
         end
         prev_sign = ref_sign(v);
         prev_bcd  = ref_bcd(v);
      end
   endtask

`ifdef BCD_LZ_BLANK_EN
   task automatic test_blank();
      logic [15:0] vals [7];
      int lat, rl, ch;
      vals = '{16'd42, 16'd0, 16'(-30000), 16'd9, 16'd10, 16'($urandom), 16'($urandom)};
      foreach (vals[k]) begin
         do_convert(vals[k], prev_sign, prev_bcd, lat, rl, ch);
         asserts++;
         if (bus.blank !== ref_blank(vals[k]) || bus.bcd !== ref_bcd(vals[k])) begin
            failures++;
            $display("FAIL blank_%h: got %b/%h want %b/%h", vals[k], bus.blank, bus.bcd,
                     ref_blank(vals[k]), ref_bcd(vals[k]));
         end
         prev_sign = ref_sign(vals[k]);
         prev_bcd  = ref_bcd(vals[k]);
      end
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.bin      = '0;
      test_reset();
      test_zero_latency();
      test_values();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
`ifdef BCD_LZ_BLANK_EN
      test_blank();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/seq_bcd_converter.md
Name: seq_bcd_converter

Overview:
Multi-cycle signed-binary to sign/BCD converter that sits directly downstream of signed_multiplier and feeds the seven-segment display driver. It accepts one product word per handshake and converts it with iterative shift-add-3 (double dabble), one bit per cycle. It presents registered sign plus BCD digits that hold stable until the next conversion completes. It replaces the large unrolled combinational converter, trading latency for area.

Parameters:
WIDTH, 16, input word width in bits (two's complement); legal range 2..16
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  bin is valid; accepted on a rising edge where in_valid && in_ready
in_ready  output  1  high only in IDLE
bin  input  WIDTH  signed two's-complement value to convert
busy  output  1  high in SHIFT and DONE
out_valid  output  1  one-cycle pulse: new sign/bcd just loaded
sign  output  1  1 = result negative
bcd  output  4*DIGITS  digit i at bits [4i+3:4i]; digit 0 = ones

Behaviour:
- Reset (async, active-high; clock clk): state=IDLE, out_valid=0, sign=0, bcd=0, busy=0, counter=0, internal shift register=0; in_ready=1 once reset deasserts.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE: in_ready=1. On accept edge:
  - capture neg=bin[WIDTH-1]
  - mag = neg ? -bin : bin, taken as WIDTH-bit unsigned
  - most-negative input (e.g. 0x8000) gives magnitude 2^(WIDTH-1) with no overflow
  - clear BCD field, counter=WIDTH, go to SHIFT
- SHIFT: each cycle, every BCD digit >= 5 gets +3, then {bcd_field, mag} shifts left by 1 and counter decrements. When counter reaches 1 on the shift edge, go to DONE, so exactly WIDTH shift cycles occur.
- DONE: on the next edge, load sign<=neg, bcd<=bcd_field, out_valid<=1, go to IDLE. out_valid drops on the following edge.
- Latency: with acceptance on edge T, out_valid is high in the cycle after edge T+WIDTH+1 (17 edges at WIDTH=16).
- Throughput: one conversion per WIDTH+2 cycles.
- in_valid while busy is ignored (in_ready=0); there is no queueing.
- A new acceptance in the same cycle that out_valid is high is legal; sign/bcd hold until the next DONE.
- sign and bcd change only on a DONE edge or on reset. They never show intermediate shift values.
- Zero input: sign=0, all digits 0. Negative zero cannot occur.
- Reset mid-conversion aborts immediately: no out_valid, outputs cleared to 0, and the in-flight value is discarded.
- bin is sampled only at acceptance; later changes to bin have no effect.

Optional Feature:
Macro BCD_LZ_BLANK_EN.
- Defined:
  - adds output port blank, width DIGITS, registered with bcd on the DONE edge, reset value 0
  - blank[i]=1 when digit i and every higher digit are 0, for i >= 1
  - blank[0] is always 0, so the ones digit is never blanked
  - lets the display suppress leading zeros
- Undefined: port blank absent; all other behaviour identical.

Test Plan:
1. Reset, then accept bin=16'h0000 -> exactly 17 edges later out_valid pulses for 1 cycle; sign=0, bcd=20'h00000; in_ready low for the 17 intervening cycles.
2. Accept bin=16'd12345 -> sign=0, bcd=20'h12345; accept bin=16'hFFFF (-1) -> sign=1, bcd=20'h00001.
3. Accept bin=16'h8000 -> sign=1, bcd=20'h32768; accept 16'h7FFF -> sign=0, bcd=20'h32767.
4. Accept bin=100, hold in_valid with bin=99 throughout busy -> single out_valid with bcd=20'h00100; 99 accepted on the first in_ready edge and delivers bcd=20'h00099 one conversion later.
5. Complete bin=-250 (sign=1, bcd=20'h00250), accept 9999, assert reset 8 cycles in -> no out_valid, sign=0, bcd=0 immediately; after release, in_ready=1 and bin=7 converts to bcd=20'h00007.
6. With BCD_LZ_BLANK_EN: bin=42 -> blank=5'b11100; bin=0 -> blank=5'b11110; bin=-30000 -> blank=5'b00000.
